// File: rtl/tile_renderer.sv
// Pixel stage behind a 640x480 VGA timing generator: draws a 20x15 board of 32x32 tiles
// from an internal tile RAM, with grid lines, a blinking cursor and a tear-free write port.
module tile_renderer #(
  parameter int TILE_LOG2 = 5,
  parameter int COLS      = 20,
  parameter int ROWS      = 15,
  parameter int BLINK_BIT = 4
) (
  input  logic       clk_25,
  input  logic       rst,
  input  logic [9:0] hs,
  input  logic [9:0] vs,
  input  logic       vis_in,
  input  logic       hsync_in,
  input  logic       vsync_in,
  input  logic       wr_valid,
  output logic       wr_ready,
  input  logic [4:0] wr_col,
  input  logic [3:0] wr_row,
  input  logic [2:0] wr_color,
  input  logic [4:0] cursor_col,
  input  logic [3:0] cursor_row,
  output logic [7:0] vga_r,
  output logic [7:0] vga_g,
  output logic [7:0] vga_b,
  output logic       vga_hsync,
  output logic       vga_vsync,
  output logic       vga_blk,
  output logic       vga_sync
);

  localparam int         NTILES    = COLS * ROWS;
  localparam logic [9:0] NTILES_W  = 10'(NTILES);
  localparam logic [9:0] COLS_W    = 10'(COLS);
  localparam logic [8:0] COLS_9    = 9'(COLS);
  localparam logic [4:0] COLS_C    = 5'(COLS);
  localparam logic [3:0] ROWS_R    = 4'(ROWS);
  localparam logic [8:0] CLR_LAST  = 9'(NTILES - 1);
  localparam logic [9:0] V_VISIBLE = 10'd480;

  typedef enum logic [1:0] {ST_CLEAR, ST_IDLE, ST_HOLD} wr_state_t;

  function automatic logic [23:0] palette(input logic [2:0] idx);
    case (idx)
      3'd0:    return 24'h000000;
      3'd1:    return 24'hFF0000;
      3'd2:    return 24'hFFFF00;
      3'd3:    return 24'h0000FF;
      3'd4:    return 24'h00FF00;
      3'd5:    return 24'hFFFFFF;
      3'd6:    return 24'h808080;
      default: return 24'h000080;
    endcase
  endfunction

  wr_state_t r_state, w_next_state;
  logic [8:0] r_clr_addr;
  logic [4:0] r_hold_col;
  logic [3:0] r_hold_row;
  logic [2:0] r_hold_color;
  logic [5:0] r_frame_cnt;

  logic [2:0] r_tile_ram [NTILES];
  logic [2:0] r_s1_idx;
  logic [TILE_LOG2-1:0] r_s1_lx, r_s1_ly;
  logic [4:0] r_s1_tcol, r_s1_trow;
  logic       r_s1_vis, r_hs_d1, r_vs_d1;
  logic [23:0] r_rgb;
  logic       r_hsync, r_vsync, r_blk, r_sync;

  logic [9:0] w_hs_tile, w_vs_tile, w_rd_addr;
  logic       w_rd_hit, w_vblank, w_frame_tick;
  logic [8:0] w_hold_addr;
  logic       w_hold_ok;
  logic       w_ram_we;
  logic [8:0] w_ram_waddr;
  logic [2:0] w_ram_wdata;
  logic       w_cur_tile, w_lx_edge, w_ly_edge;
  logic [23:0] w_pix_rgb;

  assign w_hs_tile    = hs >> TILE_LOG2;
  assign w_vs_tile    = vs >> TILE_LOG2;
  assign w_rd_addr    = w_vs_tile * COLS_W + w_hs_tile;
  assign w_rd_hit     = w_rd_addr < NTILES_W;
  assign w_vblank     = vs >= V_VISIBLE;
  assign w_frame_tick = (hs == '0) && (vs == V_VISIBLE);
  assign w_hold_addr  = 9'(r_hold_row) * COLS_9 + 9'(r_hold_col);
  assign w_hold_ok    = (r_hold_col < COLS_C) && (r_hold_row < ROWS_R);

  // Write FSM: state register
  always_ff @(posedge clk_25 or posedge rst) begin
    if (rst) r_state <= ST_CLEAR;
    else     r_state <= w_next_state;
  end

  // Write FSM: next state
  always_comb begin
    w_next_state = r_state;
    unique case (r_state)
      ST_CLEAR: if (r_clr_addr == CLR_LAST) w_next_state = ST_IDLE;
      ST_IDLE:  if (wr_valid)               w_next_state = ST_HOLD;
      ST_HOLD:  if (w_vblank)               w_next_state = ST_IDLE;
      default:                              w_next_state = ST_CLEAR;
    endcase
  end

  // Write FSM: outputs and RAM write port
  always_comb begin
    // NOTE: every signal gets a default before the case so no path can infer a latch.
    wr_ready    = 1'b0;
    w_ram_we    = 1'b0;
    w_ram_waddr = r_clr_addr;
    w_ram_wdata = '0;
    unique case (r_state)
      ST_CLEAR: w_ram_we = 1'b1;
      ST_IDLE:  wr_ready = 1'b1;
      ST_HOLD: begin
        w_ram_we    = w_vblank && w_hold_ok;
        w_ram_waddr = w_hold_addr;
        w_ram_wdata = r_hold_color;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_25 or posedge rst) begin
    if (rst) begin
      r_clr_addr   <= '0;
      r_hold_col   <= '0;
      r_hold_row   <= '0;
      r_hold_color <= '0;
      r_frame_cnt  <= '0;
    end else begin
      if (r_state == ST_CLEAR) r_clr_addr <= r_clr_addr + 9'd1;
      if (r_state == ST_IDLE && wr_valid) begin
        r_hold_col   <= wr_col;
        r_hold_row   <= wr_row;
        r_hold_color <= wr_color;
      end
      if (w_frame_tick) r_frame_cnt <= r_frame_cnt + 6'd1;
    end
  end

  // NOTE: the tile RAM has no reset; the CLEAR sweep initialises it so it maps onto block RAM.
  always_ff @(posedge clk_25) begin
    if (w_ram_we) r_tile_ram[w_ram_waddr] <= w_ram_wdata;
    r_s1_idx <= w_rd_hit ? r_tile_ram[w_rd_addr[8:0]] : '0;
  end

  // Stage 1: pixel position within the tile and the tile coordinates
  always_ff @(posedge clk_25 or posedge rst) begin
    if (rst) begin
      r_s1_lx   <= '0;
      r_s1_ly   <= '0;
      r_s1_tcol <= '0;
      r_s1_trow <= '0;
      r_s1_vis  <= 1'b0;
      r_hs_d1   <= 1'b1;
      r_vs_d1   <= 1'b1;
    end else begin
      r_s1_lx   <= hs[TILE_LOG2-1:0];
      r_s1_ly   <= vs[TILE_LOG2-1:0];
      r_s1_tcol <= w_hs_tile[4:0];
      r_s1_trow <= w_vs_tile[4:0];
      r_s1_vis  <= vis_in;
      r_hs_d1   <= hsync_in;
      r_vs_d1   <= vsync_in;
    end
  end

  assign w_cur_tile = (r_s1_tcol == cursor_col) && (r_s1_trow == {1'b0, cursor_row}) &&
                      (cursor_col < COLS_C) && (cursor_row < ROWS_R);
  // Two-pixel border on every side of the cursor tile
  assign w_lx_edge  = (r_s1_lx[TILE_LOG2-1:1] == '0) || (r_s1_lx[TILE_LOG2-1:1] == '1);
  assign w_ly_edge  = (r_s1_ly[TILE_LOG2-1:1] == '0) || (r_s1_ly[TILE_LOG2-1:1] == '1);

  always_comb begin
    w_pix_rgb = '0;
    if (r_s1_vis) begin
      if (w_cur_tile && !r_frame_cnt[BLINK_BIT] && (w_lx_edge || w_ly_edge))
        w_pix_rgb = 24'hFFFFFF;
      else if (r_s1_lx == '0 || r_s1_ly == '0)
        w_pix_rgb = 24'h808080;
      else
        w_pix_rgb = palette(r_s1_idx);
    end
  end

  // Stage 2: output registers
  always_ff @(posedge clk_25 or posedge rst) begin
    if (rst) begin
      r_rgb   <= '0;
      r_hsync <= 1'b1;
      r_vsync <= 1'b1;
      r_blk   <= 1'b0;
      r_sync  <= 1'b1;
    end else begin
      r_rgb   <= w_pix_rgb;
      r_hsync <= r_hs_d1;
      r_vsync <= r_vs_d1;
      r_blk   <= r_s1_vis;
      r_sync  <= r_hs_d1 & r_vs_d1;
    end
  end

  assign vga_r     = r_rgb[23:16];
  assign vga_g     = r_rgb[15:8];
  assign vga_b     = r_rgb[7:0];
  assign vga_hsync = r_hsync;
  assign vga_vsync = r_vsync;
  assign vga_blk   = r_blk;
  assign vga_sync  = r_sync;

endmodule

// File: tb/tb_tile_renderer.sv
// Bench for tile_renderer: the bench acts as the timing generator and checks every output
// against a frame-level model of the tile board, write handshake and cursor blink.
module tb_tile_renderer;

  logic       clk_25 = 1'b0;
  logic       rst = 1'b0;
  logic [9:0] hs, vs;
  logic       vis_in, hsync_in, vsync_in;
  logic       wr_valid, wr_ready;
  logic [4:0] wr_col;
  logic [3:0] wr_row;
  logic [2:0] wr_color;
  logic [4:0] cursor_col;
  logic [3:0] cursor_row;
  logic [7:0] vga_r, vga_g, vga_b;
  logic       vga_hsync, vga_vsync, vga_blk, vga_sync;

  tile_renderer dut (
    .clk_25(clk_25), .rst(rst), .hs(hs), .vs(vs), .vis_in(vis_in),
    .hsync_in(hsync_in), .vsync_in(vsync_in), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_col(wr_col), .wr_row(wr_row), .wr_color(wr_color),
    .cursor_col(cursor_col), .cursor_row(cursor_row),
    .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
    .vga_hsync(vga_hsync), .vga_vsync(vga_vsync), .vga_blk(vga_blk), .vga_sync(vga_sync)
  );

  always #20 clk_25 = ~clk_25;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // Reference model state
  logic [23:0] pal [8] = '{24'h000000, 24'hFF0000, 24'hFFFF00, 24'h0000FF,
                           24'h00FF00, 24'hFFFFFF, 24'h808080, 24'h000080};
  int tiles [300];
  int fc;
  int clear_left;
  bit pend;
  int p_col, p_row, p_color;

  typedef struct {
    logic [23:0] rgb;
    bit          chk_rgb;
    logic        hsync, vsync, blk;
  } exp_t;
  exp_t q[$];

  function automatic logic [23:0] model_rgb(input int h, input int v);
    int c, r, lx, ly;
    c = h / 32; r = v / 32; lx = h % 32; ly = v % 32;
    if (!(h < 640 && v < 480)) return 24'h0;
    if (c == int'(cursor_col) && r == int'(cursor_row) && ((fc / 16) % 2) == 0 &&
        (lx < 2 || lx > 29 || ly < 2 || ly > 29)) return 24'hFFFFFF;
    if (lx == 0 || ly == 0) return 24'h808080;
    return pal[tiles[r * 20 + c]];
  endfunction

  task automatic model_init();
    foreach (tiles[i]) tiles[i] = 0;
    fc = 0; clear_left = 300; pend = 0;
    q.delete();
  endtask

  task automatic set_pix(input int h, input int v);
    hs       = 10'(h);
    vs       = 10'(v);
    vis_in   = (h < 640) && (v < 480);
    hsync_in = !(h >= 656 && h < 752);
    vsync_in = !(v >= 490 && v < 492);
  endtask

  // One pixel clock: check handshake, record expectation, update model, compare 2-cycle-old pixel.
  task automatic step();
    exp_t e;
    int h, v;
    h = int'(hs); v = int'(vs);
    check("wr_ready", wr_ready, (clear_left == 0 && !pend));
    e.rgb = model_rgb(h, v);
    e.chk_rgb = (clear_left == 0);
    e.hsync = hsync_in; e.vsync = vsync_in; e.blk = vis_in;
    q.push_back(e);
    @(posedge clk_25);
    if (clear_left > 0) clear_left--;
    else if (pend) begin
      if (v >= 480) begin
        if (p_col < 20 && p_row < 15) tiles[p_row * 20 + p_col] = p_color;
        pend = 0;
      end
    end else if (wr_valid) begin
      pend = 1; p_col = int'(wr_col); p_row = int'(wr_row); p_color = int'(wr_color);
    end
    if (h == 0 && v == 480) fc = (fc + 1) % 64;
    @(negedge clk_25);
    if (q.size() == 2) begin
      e = q.pop_front();
      if (e.chk_rgb) check("rgb", {vga_r, vga_g, vga_b}, e.rgb);
      check("hsync", vga_hsync, e.hsync);
      check("vsync", vga_vsync, e.vsync);
      check("blk",   vga_blk,   e.blk);
      check("sync",  vga_sync,  e.hsync & e.vsync);
    end
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    #1;
    check("rst_rgb",   {vga_r, vga_g, vga_b}, 24'h0);
    check("rst_hsync", vga_hsync, 1'b1);
    check("rst_vsync", vga_vsync, 1'b1);
    check("rst_sync",  vga_sync,  1'b1);
    check("rst_blk",   vga_blk,   1'b0);
    check("rst_ready", wr_ready,  1'b0);
    @(negedge clk_25);
    @(negedge clk_25);
    rst = 1'b0;
    model_init();
  endtask

  task automatic clear_length(input string tag);
    int n;
    n = 0;
    set_pix(700, 500);
    while (!wr_ready && n < 1000) begin step(); n++; end
    check(tag, n, 300);
  endtask

  task automatic probe(input string tag, input int h, input int v, input logic [23:0] exp);
    set_pix(h, v); step();
    set_pix(700, 500); step();
    check(tag, {vga_r, vga_g, vga_b}, exp);
  endtask

  task automatic issue_write(input int c, input int r, input int k);
    int n;
    n = 0;
    set_pix(700, 500);
    while (!wr_ready && n < 2000) begin step(); n++; end
    check("wr_wait_bound", (n < 2000), 1'b1);
    wr_col = 5'(c); wr_row = 4'(r); wr_color = 3'(k); wr_valid = 1'b1;
    step();
    wr_valid = 1'b0;
    step();
  endtask

  initial begin
    logic [23:0] exp_b;
    set_pix(700, 500);
    wr_valid = 1'b0; wr_col = '0; wr_row = '0; wr_color = '0;
    cursor_col = 5'd31; cursor_row = 4'd15;
    #5;
    apply_reset();
    clear_length("clear_len");
    probe("pix_40_40", 40, 40, 24'h000000);

    // Sync and blank delay around the end of a visible line
    for (int h = 632; h < 664; h++) begin set_pix(h, 10); step(); end

    // Write during active video must wait for vblank
    set_pix(100, 100);
    wr_col = 5'd2; wr_row = 4'd3; wr_color = 3'd1; wr_valid = 1'b1;
    step();
    wr_valid = 1'b0;
    for (int v = 101; v < 480; v++) begin set_pix(0, v); step(); end
    check("hold_ready", wr_ready, 1'b0);
    set_pix(0, 480); step();
    check("commit_ready", wr_ready, 1'b1);
    probe("pix_70_100", 70, 100, 24'hFF0000);
    probe("pix_64_100", 64, 100, 24'h808080);

    // Cursor blink over more than one frame-counter wrap
    issue_write(0, 0, 3);
    cursor_col = 5'd0; cursor_row = 4'd0;
    for (int f = 0; f < 70; f++) begin
      exp_b = (((fc / 16) % 2) == 0) ? 24'hFFFFFF : 24'h0000FF;
      probe("blink_border", 1, 10, exp_b);
      probe("blink_center", 15, 15, 24'h0000FF);
      set_pix(0, 480); step();
    end
    set_pix(700, 500); step();
    cursor_col = 5'd31; cursor_row = 4'd15;

    // Out-of-range writes leave the board untouched
    issue_write(25, 3, 5);
    issue_write(2, 15, 6);
    for (int r = 0; r < 15; r++)
      for (int c = 0; c < 20; c++) begin set_pix(c * 32 + 5, r * 32 + 5); step(); end
    probe("oor_tile_2_3", 70, 100, 24'hFF0000);

    // Randomised traffic
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 199) == 0) begin
        set_pix(700, 500); step();
        cursor_col = 5'($urandom_range(0, 21));
        cursor_row = 4'($urandom_range(0, 15));
      end
      if ($urandom_range(0, 99) < 3) set_pix(0, 480);
      else if ($urandom_range(0, 3) == 0 && cursor_col < 20 && cursor_row < 15)
        set_pix(int'(cursor_col) * 32 + $urandom_range(0, 31),
                int'(cursor_row) * 32 + $urandom_range(0, 31));
      else set_pix($urandom_range(0, 799), $urandom_range(0, 524));
      wr_valid = ($urandom_range(0, 7) == 0);
      wr_col   = 5'($urandom_range(0, 23));
      wr_row   = 4'($urandom_range(0, 15));
      wr_color = 3'($urandom_range(0, 7));
      step();
    end
    wr_valid = 1'b0;
    set_pix(700, 500); step(); step();
    cursor_col = 5'd31; cursor_row = 4'd15;

    // Reset while a write is held: the write is lost and CLEAR repeats
    set_pix(200, 200);
    wr_col = 5'd6; wr_row = 4'd6; wr_color = 3'd2; wr_valid = 1'b1;
    step();
    wr_valid = 1'b0;
    check("hold_before_rst", wr_ready, 1'b0);
    set_pix(70, 100); step(); step();
    apply_reset();
    clear_length("clear_len_again");
    probe("lost_write_tile", 6 * 32 + 5, 6 * 32 + 5, 24'h000000);
    set_pix(0, 480); step();
    probe("lost_write_after_vblank", 6 * 32 + 5, 6 * 32 + 5, 24'h000000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
